// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int INSTR_BYTES = 4;
  localparam int PERF_W      = 32;
  localparam int PC_W        = 32;

  // One prefetched instruction together with the address it was fetched from.
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: imem request/response, execute redirect and decode handshake.
interface fetch_unit_if #(
  parameter int XLEN = 32
);

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;

  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  logic            dec_valid;
  logic            dec_ready;
  logic [31:0]     dec_instr;
  logic [XLEN-1:0] dec_pc;

  // The fetch unit side drives requests and decode data.
  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  redirect_valid,
    input  redirect_pc,
    output dec_valid,
    output dec_instr,
    output dec_pc,
    input  dec_ready
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    output redirect_valid,
    output redirect_pc,
    input  dec_valid,
    input  dec_instr,
    input  dec_pc,
    output dec_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// First-word-fall-through prefetch FIFO of fetch entries with synchronous flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         empty,
  output logic         full,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;

  // When full, wr_ptr equals rd_ptr; a simultaneous push overwrites the slot being popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Pipelined RV32I instruction-fetch front end with prefetch FIFO and redirect handling.
// Optional FETCH_PERF_CNT_EN adds perf_fetched/perf_redirects/perf_dropped counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN            = 32,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_unit_if.master      bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_fetched,
  output logic [PERF_W-1:0] perf_redirects,
  output logic [PERF_W-1:0] perf_dropped
`endif
);

  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int FCW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] rsp_pc_q;
  logic [OW-1:0]   outstanding_q;
  logic [OW-1:0]   discard_q;

  logic            req_fire;
  logic            rsp_ok;
  logic            push;
  logic            pop;
  logic            drop;
  logic            fifo_empty;
  logic            fifo_full;
  logic [FCW-1:0]  fifo_count;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;
  logic [XLEN-1:0] target_pc;
  int              inflight;

  // Slots already claimed in the FIFO: queued entries plus responses that will be kept.
  always_comb begin
    inflight = int'(fifo_count) + int'(outstanding_q) - int'(discard_q);
  end

  // rst_n gating keeps the request quiet while reset is held yet lets it issue right after release.
  assign bus.imem_req_valid = rst_n && !bus.redirect_valid &&
                              (int'(outstanding_q) < MAX_OUTSTANDING) &&
                              (inflight < DEPTH);
  assign bus.imem_req_addr  = pc_q;

  assign req_fire  = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_ok    = bus.imem_rsp_valid && (outstanding_q != '0);
  assign push      = bus.imem_rsp_valid && !bus.redirect_valid && (discard_q == '0);
  assign drop      = bus.imem_rsp_valid && (bus.redirect_valid || (discard_q != '0));
  assign target_pc = {bus.redirect_pc[XLEN-1:2], 2'b00};

  assign bus.dec_valid = !fifo_empty && !bus.redirect_valid;
  assign pop           = bus.dec_valid && bus.dec_ready;
  assign bus.dec_instr = head.instr;
  assign bus.dec_pc    = XLEN'(head.pc);

  assign push_entry.pc    = PC_W'(rsp_pc_q);
  assign push_entry.instr = bus.imem_rsp_data;

  // A redirect re-bases both PCs and marks every response still in flight as stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else if (bus.redirect_valid) begin
      pc_q          <= target_pc;
      rsp_pc_q      <= target_pc;
      outstanding_q <= outstanding_q - OW'(rsp_ok);
      discard_q     <= outstanding_q - OW'(rsp_ok);
    end else begin
      if (req_fire) begin
        pc_q <= pc_q + XLEN'(INSTR_BYTES);
      end
      if (push) begin
        rsp_pc_q <= rsp_pc_q + XLEN'(INSTR_BYTES);
      end
      outstanding_q <= outstanding_q + OW'(req_fire) - OW'(rsp_ok);
      if (bus.imem_rsp_valid && (discard_q != '0)) begin
        discard_q <= discard_q - OW'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (bus.redirect_valid),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .head     (head),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_count)
  );

`ifdef FETCH_PERF_CNT_EN
  // Dropped includes words discarded as stale and words arriving during a redirect pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched   <= '0;
      perf_redirects <= '0;
      perf_dropped   <= '0;
    end else begin
      if (pop) begin
        perf_fetched <= perf_fetched + PERF_W'(1);
      end
      if (bus.redirect_valid) begin
        perf_redirects <= perf_redirects + PERF_W'(1);
      end
      if (drop) begin
        perf_dropped <= perf_dropped + PERF_W'(1);
      end
    end
  end
`else
  logic unused_ok;
  assign unused_ok = drop ^ fifo_full;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a latency-programmable in-order imem model.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam int          MAXO     = 2;
  localparam logic [31:0] RST_PC   = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(XLEN)) bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_redirects;
  logic [31:0] perf_dropped;
`endif

  fetch_unit #(
    .XLEN           (XLEN),
    .DEPTH          (DEPTH),
    .MAX_OUTSTANDING(MAXO),
    .RESET_PC       (RST_PC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_redirects(perf_redirects),
    .perf_dropped  (perf_dropped)
`endif
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lat = 1;
  int hold_err;
  int low_pc;

  logic [31:0] q_addr [$];
  int          q_due  [$];
  logic [31:0] req_log [$];
  logic [31:0] log_pc [$];
  logic [31:0] log_instr [$];

  logic        obs_req_valid;
  logic [31:0] obs_req_addr;
  logic        obs_dec_valid;
  logic [31:0] obs_dec_pc;
  logic [31:0] obs_dec_instr;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  function automatic logic [31:0] log_at(input int i);
    return (i < log_pc.size()) ? log_pc[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: present the due response, sample outputs, log handshakes, advance.
  task automatic apply_stimulus(input logic redir, input logic [31:0] rpc, input logic rdy);
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.dec_ready      = rdy;
    if (q_due.size() > 0 && q_due[0] == cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = instr_of(q_addr[0]);
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end
    #1;
    obs_req_valid = bus.imem_req_valid;
    obs_req_addr  = bus.imem_req_addr;
    obs_dec_valid = bus.dec_valid;
    obs_dec_pc    = bus.dec_pc;
    obs_dec_instr = bus.dec_instr;
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      q_addr.push_back(bus.imem_req_addr);
      q_due.push_back(cyc + lat);
      req_log.push_back(bus.imem_req_addr);
      check_output("inflight_limit", 32'(q_addr.size() <= MAXO), 32'd1);
    end
    if (bus.dec_valid && bus.dec_ready) begin
      log_pc.push_back(bus.dec_pc);
      log_instr.push_back(bus.dec_instr);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(input int l);
    rst_n              = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.dec_ready      = 1'b0;
    lat = l;
    q_addr.delete();
    q_due.delete();
    req_log.delete();
    log_pc.delete();
    log_instr.delete();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    // Reset values while rst_n is held low.
    rst_n = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.dec_ready      = 1'b1;
    @(negedge clk);
    check_output("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check_output("rst_dec_valid", 32'(bus.dec_valid), 32'd0);
    check_output("rst_dec_pc", bus.dec_pc, 32'd0);
    check_output("rst_dec_instr", bus.dec_instr, 32'd0);

    // Streaming with latency 1.
    do_reset(1);
    apply_stimulus(1'b0, '0, 1'b1);
    check_output("s1_c0_req_valid", 32'(obs_req_valid), 32'd1);
    check_output("s1_c0_req_addr", obs_req_addr, 32'h100);
    check_output("s1_c0_dec_valid", 32'(obs_dec_valid), 32'd0);
    apply_stimulus(1'b0, '0, 1'b1);
    check_output("s1_c1_req_addr", obs_req_addr, 32'h104);
    check_output("s1_c1_dec_valid", 32'(obs_dec_valid), 32'd0);
    apply_stimulus(1'b0, '0, 1'b1);
    check_output("s1_c2_req_addr", obs_req_addr, 32'h108);
    check_output("s1_c2_dec_valid", 32'(obs_dec_valid), 32'd1);
    check_output("s1_c2_dec_pc", obs_dec_pc, 32'h100);
    check_output("s1_c2_dec_instr", obs_dec_instr, instr_of(32'h100));
    for (int i = 3; i < 10; i++) apply_stimulus(1'b0, '0, 1'b1);
    check_output("s1_log_size", 32'(log_pc.size()), 32'd8);
    for (int i = 0; i < 6; i++) begin
      check_output("s1_seq_pc", log_at(i), 32'h100 + 32'(4 * i));
      check_output("s1_seq_instr", (i < log_instr.size()) ? log_instr[i] : 32'hDEAD_BEEF,
                   instr_of(32'h100 + 32'(4 * i)));
    end

    // Decode stalled: credits stop requests at DEPTH, head holds, then drains in order.
    do_reset(1);
    hold_err = 0;
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(1'b0, '0, 1'b0);
      if (i >= 2 && !(obs_dec_valid && obs_dec_pc == 32'h100 && obs_dec_instr == instr_of(32'h100)))
        hold_err++;
    end
    check_output("s2_req_count", 32'(req_log.size()), 32'd4);
    check_output("s2_last_req", (req_log.size() == 4) ? req_log[3] : 32'hDEAD_BEEF, 32'h10C);
    check_output("s2_req_stopped", 32'(obs_req_valid), 32'd0);
    check_output("s2_hold_stable", 32'(hold_err), 32'd0);
    for (int i = 0; i < 10; i++) apply_stimulus(1'b0, '0, 1'b1);
    check_output("s2_drain_size", 32'(log_pc.size()), 32'd10);
    for (int i = 0; i < 8; i++) check_output("s2_drain_pc", log_at(i), 32'h100 + 32'(4 * i));
    log_pc.delete();
    apply_stimulus(1'b1, 32'h500, 1'b0);
    check_output("s2_redir_dec_valid", 32'(obs_dec_valid), 32'd0);
    check_output("s2_redir_req_valid", 32'(obs_req_valid), 32'd0);
    apply_stimulus(1'b0, '0, 1'b1);
    check_output("s2_flush_dec_valid", 32'(obs_dec_valid), 32'd0);
    check_output("s2_target_req", obs_req_addr, 32'h500);
    apply_stimulus(1'b0, '0, 1'b1);
    apply_stimulus(1'b0, '0, 1'b1);
    check_output("s2_first_after_flush", log_at(0), 32'h500);

    // Latency 3, redirect with two requests in flight.
    do_reset(3);
    apply_stimulus(1'b0, '0, 1'b1);
    check_output("s3_c0_req_addr", obs_req_addr, 32'h100);
    apply_stimulus(1'b0, '0, 1'b1);
    check_output("s3_c1_req_addr", obs_req_addr, 32'h104);
    apply_stimulus(1'b1, 32'h200, 1'b1);
    check_output("s3_redir_req_valid", 32'(obs_req_valid), 32'd0);
    for (int i = 0; i < 20; i++) apply_stimulus(1'b0, '0, 1'b1);
    low_pc = 0;
    foreach (log_pc[i]) if (log_pc[i] < 32'h200) low_pc++;
    check_output("s3_no_stale_pc", 32'(low_pc), 32'd0);
    check_output("s3_first_pc", log_at(0), 32'h200);
    check_output("s3_second_pc", log_at(1), 32'h204);
    check_output("s3_first_instr", (log_instr.size() > 0) ? log_instr[0] : 32'hDEAD_BEEF,
                 instr_of(32'h200));
`ifdef FETCH_PERF_CNT_EN
    check_output("s3_perf_redirects", perf_redirects, 32'd1);
    check_output("s3_perf_dropped", perf_dropped, 32'd2);
    check_output("s3_perf_fetched", perf_fetched, 32'(log_pc.size()));
`endif

    // Redirect coinciding with the only outstanding response.
    do_reset(1);
    apply_stimulus(1'b0, '0, 1'b1);
    apply_stimulus(1'b1, 32'h200, 1'b1);
    check_output("s4_redir_req_valid", 32'(obs_req_valid), 32'd0);
    apply_stimulus(1'b0, '0, 1'b1);
    check_output("s4_req_valid", 32'(obs_req_valid), 32'd1);
    check_output("s4_req_addr", obs_req_addr, 32'h200);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, '0, 1'b1);
    check_output("s4_first_pc", log_at(0), 32'h200);

    // Misaligned target and back-to-back redirects.
    do_reset(1);
    apply_stimulus(1'b0, '0, 1'b1);
    apply_stimulus(1'b1, 32'h203, 1'b1);
    apply_stimulus(1'b0, '0, 1'b1);
    check_output("s5_align_req_valid", 32'(obs_req_valid), 32'd1);
    check_output("s5_align_req_addr", obs_req_addr, 32'h200);
    apply_stimulus(1'b1, 32'h300, 1'b1);
    apply_stimulus(1'b1, 32'h400, 1'b1);
    apply_stimulus(1'b0, '0, 1'b1);
    check_output("s5_b2b_req_addr", obs_req_addr, 32'h400);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, '0, 1'b1);
    check_output("s5_first_pc", log_at(0), 32'h400);
`ifdef FETCH_PERF_CNT_EN
    check_output("s5_perf_redirects", perf_redirects, 32'd3);
    check_output("s5_perf_dropped", perf_dropped, 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
